// File: rtl/gesture_score_sequencer_if.sv
// Control, memory-read and result signals of the gesture score sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding logic's view.
interface gesture_score_sequencer_if #(
    parameter int NUM_CLASSES = 4,
    parameter int NUM_CELLS   = 1024,
    parameter int WEIGHT_BITS = 8,
    parameter int FEAT_BITS   = 4,
    parameter int ACC_BITS    = 24
);
    localparam int ADDR_W = $clog2(NUM_CELLS);
    localparam int CLS_W  = $clog2(NUM_CLASSES);
    localparam int ACT_W  = FEAT_BITS + ADDR_W;

    logic                            start;
    logic                            abort;
    logic                            busy;
    logic                            done;
    logic                            rd_en;
    logic [ADDR_W-1:0]               cell_addr;
    logic [FEAT_BITS-1:0]            feat_data;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_data;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores;
    logic [ACT_W-1:0]                activity;
    logic [CLS_W-1:0]                gesture_class;
    logic                            gesture_valid;

    modport slave (
        input  start, abort, feat_data, weight_data,
        output busy, done, rd_en, cell_addr, scores, activity, gesture_class, gesture_valid
    );

    modport master (
        output start, abort, feat_data, weight_data,
        input  busy, done, rd_en, cell_addr, scores, activity, gesture_class, gesture_valid
    );
endinterface

// File: rtl/gesture_score_sequencer.sv
// Sweeps all grid cells once, accumulates a signed dot product per class and registers the argmax.
// done pulses NUM_CELLS+3 cycles after start is taken; no backpressure, abort returns to idle keeping old results.
module gesture_score_sequencer #(
    parameter int NUM_CLASSES  = 4,
    parameter int NUM_CELLS    = 1024,
    parameter int WEIGHT_BITS  = 8,
    parameter int FEAT_BITS    = 4,
    parameter int ACC_BITS     = 24,
    parameter int MIN_ACTIVITY = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    gesture_score_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_CELLS);
    localparam int CLS_W  = $clog2(NUM_CLASSES);
    localparam int ACT_W  = FEAT_BITS + ADDR_W;
    localparam int PROD_W = WEIGHT_BITS + FEAT_BITS + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);
    localparam logic [ACT_W-1:0]  MIN_ACT   = ACT_W'(MIN_ACTIVITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic                            vld_q, vld_d;
    logic                            clear_acc;
    logic signed [ACC_BITS-1:0]      acc_q [NUM_CLASSES];
    logic signed [ACC_BITS-1:0]      acc_d [NUM_CLASSES];
    logic [ACT_W-1:0]                act_sum_q, act_sum_d;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores_q, scores_d;
    logic [ACT_W-1:0]                activity_q, activity_d;
    logic [CLS_W-1:0]                cls_q, cls_d;
    logic                            gv_q, gv_d;

    logic [PROD_W-1:0]               w_ext [NUM_CLASSES];
    logic [PROD_W-1:0]               f_ext;
    logic [PROD_W-1:0]               prod  [NUM_CLASSES];
    logic [CLS_W-1:0]                best_idx;
    logic signed [ACC_BITS-1:0]      best_val;

    // Abort wins over every same-cycle transition out of RUN, DRAIN and ARGMAX.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        clear_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    addr_d    = '0;
                    clear_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN:  state_d = bus.abort ? S_IDLE : S_ARGMAX;
            S_ARGMAX: state_d = bus.abort ? S_IDLE : S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        vld_d = (state_q == S_RUN);
    end

    // Products are formed at full width; the truncated unsigned product equals the signed one.
    always_comb begin
        f_ext     = {{(WEIGHT_BITS + 1){1'b0}}, bus.feat_data};
        act_sum_d = act_sum_q;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            w_ext[k] = {{(FEAT_BITS + 1){bus.weight_data[k*WEIGHT_BITS + WEIGHT_BITS - 1]}},
                        bus.weight_data[k*WEIGHT_BITS +: WEIGHT_BITS]};
            prod[k]  = w_ext[k] * f_ext;
            acc_d[k] = acc_q[k];
            if (clear_acc) begin
                acc_d[k] = '0;
            end else if (vld_q) begin
                acc_d[k] = acc_q[k] + {{(ACC_BITS - PROD_W){prod[k][PROD_W-1]}}, prod[k]};
            end
        end
        if (clear_acc) begin
            act_sum_d = '0;
        end else if (vld_q) begin
            act_sum_d = act_sum_q + {{ADDR_W{1'b0}}, bus.feat_data};
        end
    end

    // Strictly-greater update keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = acc_q[0];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (acc_q[k] > best_val) begin
                best_val = acc_q[k];
                best_idx = CLS_W'(k);
            end
        end
    end

    always_comb begin
        scores_d   = scores_q;
        activity_d = activity_q;
        cls_d      = cls_q;
        gv_d       = gv_q;
        if (state_q == S_ARGMAX && !bus.abort) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                scores_d[k*ACC_BITS +: ACC_BITS] = acc_q[k];
            end
            activity_d = act_sum_q;
            cls_d      = best_idx;
            gv_d       = (act_sum_q >= MIN_ACT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            vld_q      <= 1'b0;
            act_sum_q  <= '0;
            scores_q   <= '0;
            activity_q <= '0;
            cls_q      <= '0;
            gv_q       <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            act_sum_q  <= act_sum_d;
            scores_q   <= scores_d;
            activity_q <= activity_d;
            cls_q      <= cls_d;
            gv_q       <= gv_d;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.rd_en         = (state_q == S_RUN);
    assign bus.cell_addr     = addr_q;
    assign bus.scores        = scores_q;
    assign bus.activity      = activity_q;
    assign bus.gesture_class = cls_q;
    assign bus.gesture_valid = gv_q;
endmodule

// File: tb/tb_gesture_score_sequencer.sv
// Scoreboard bench: each accepted start pushes a model result; every done pops and compares it.
module tb_gesture_score_sequencer;
    localparam int NC     = 4;
    localparam int NCELL  = 1024;
    localparam int WB     = 8;
    localparam int FB     = 4;
    localparam int AB     = 24;
    localparam int MINACT = 32;
    localparam int ADDR_W = $clog2(NCELL);
    localparam int ACT_W  = FB + ADDR_W;
    localparam int LAT    = NCELL + 3;

    typedef struct packed {
        logic [NC*AB-1:0] scores;
        logic [ACT_W-1:0] act;
        logic [1:0]       cls;
        logic             vld;
        logic [31:0]      start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gesture_score_sequencer_if #(
        .NUM_CLASSES(NC), .NUM_CELLS(NCELL), .WEIGHT_BITS(WB), .FEAT_BITS(FB), .ACC_BITS(AB)
    ) bus ();

    gesture_score_sequencer #(
        .NUM_CLASSES(NC), .NUM_CELLS(NCELL), .WEIGHT_BITS(WB), .FEAT_BITS(FB),
        .ACC_BITS(AB), .MIN_ACTIVITY(MINACT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [FB-1:0]        feat_m [NCELL];
    logic signed [WB-1:0] w_m    [NC][NCELL];

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory models: 1-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.feat_data <= feat_m[bus.cell_addr];
            for (int k = 0; k < NC; k++) bus.weight_data[k*WB +: WB] <= w_m[k][bus.cell_addr];
        end else begin
            bus.feat_data   <= '1;
            bus.weight_data <= {NC{8'h7f}};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] exp_addr = '0;
    bit  addr_bad = 1'b0;
    bit  prev_rd  = 1'b0;
    int  run_len  = 0;
    int  last_run_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_addr = '0;
            run_len  = 0;
            prev_rd  = 1'b0;
        end else begin
            if (bus.rd_en) begin
                if (bus.cell_addr !== exp_addr) addr_bad = 1'b1;
                exp_addr = exp_addr + 1'b1;
                run_len++;
            end else if (prev_rd) begin
                last_run_len = run_len;
                run_len      = 0;
                exp_addr     = '0;
            end
            prev_rd = bus.rd_en;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("scores",   bus.scores, mon_e.scores);
                    check("activity", bus.activity, mon_e.act);
                    check("class",    bus.gesture_class, mon_e.cls);
                    check("valid",    bus.gesture_valid, mon_e.vld);
                    check("latency",  cyc - int'(mon_e.start_cyc), LAT);
                    check("addr_seq", addr_bad, 0);
                    check("run_len",  last_run_len, NCELL);
                    addr_bad = 1'b0;
                    last_exp = mon_e;
                end
            end
        end
    end

    function automatic exp_t model();
        exp_t e;
        int   sc[NC];
        int   act;
        int   best;
        act = 0;
        for (int k = 0; k < NC; k++) sc[k] = 0;
        for (int c = 0; c < NCELL; c++) begin
            act += int'(feat_m[c]);
            for (int k = 0; k < NC; k++) sc[k] += int'(w_m[k][c]) * int'(feat_m[c]);
        end
        best = 0;
        for (int k = 1; k < NC; k++) if (sc[k] > sc[best]) best = k;
        e = '0;
        for (int k = 0; k < NC; k++) e.scores[k*AB +: AB] = sc[k][AB-1:0];
        e.act = act[ACT_W-1:0];
        e.cls = best[1:0];
        e.vld = (act >= MINACT);
        return e;
    endfunction

    task automatic chk_reset_vals(input string pre);
        check({pre, "_busy"},     bus.busy, 0);
        check({pre, "_done"},     bus.done, 0);
        check({pre, "_rd_en"},    bus.rd_en, 0);
        check({pre, "_addr"},     bus.cell_addr, 0);
        check({pre, "_scores"},   bus.scores, 0);
        check({pre, "_activity"}, bus.activity, 0);
        check({pre, "_class"},    bus.gesture_class, 0);
        check({pre, "_valid"},    bus.gesture_valid, 0);
    endtask

    task automatic wait_done(input int n0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != n0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic run_pass(input bit with_abort);
        exp_t e;
        int   n0;
        e = model();
        @(negedge clk);
        n0 = done_cnt;
        e.start_cyc = cyc;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_done(n0);
    endtask

    task automatic fill_spec();
        int cy, cx, up, lr;
        for (int c = 0; c < NCELL; c++) begin
            cy = c / 32;
            cx = c % 32;
            up = (cy < 16) ? 6 * (16 - cy) : -4 * (cy - 15);
            lr = (cx < 16) ? 2 * (16 - cx) : -2 * (cx - 15);
            feat_m[c]  = (cy < 16) ? 4'd1 : 4'd0;
            w_m[0][c]  = 8'(up);
            w_m[1][c]  = 8'(-up);
            w_m[2][c]  = 8'(lr);
            w_m[3][c]  = 8'(-lr);
        end
    endtask

    task automatic fill_random(input int feat_lo, input int feat_hi);
        for (int c = 0; c < NCELL; c++) begin
            feat_m[c] = 4'($urandom_range(feat_hi, feat_lo));
            for (int k = 0; k < NC; k++) w_m[k][c] = 8'($urandom());
        end
    endtask

    task automatic fill_count(input int n_ones);
        for (int c = 0; c < NCELL; c++) begin
            feat_m[c] = (c < n_ones) ? 4'd1 : 4'd0;
            for (int k = 0; k < NC; k++) w_m[k][c] = 8'($urandom());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t saved;
        int   n0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        fill_count(0);
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Spec pattern: top half active, UP ramps downwards.
        fill_spec();
        run_pass(1'b0);
        check("spec_score0",   bus.scores[AB-1:0], 24'd26112);
        check("spec_activity", bus.activity, 14'd512);
        check("spec_class",    bus.gesture_class, 2'd0);
        check("spec_valid",    bus.gesture_valid, 1'b1);

        // All features zero: every score ties at 0.
        fill_random(0, 0);
        run_pass(1'b0);
        check("zero_class", bus.gesture_class, 2'd0);
        check("zero_valid", bus.gesture_valid, 1'b0);

        // Classes 1 and 3 identical and maximal.
        for (int c = 0; c < NCELL; c++) begin
            feat_m[c] = 4'($urandom_range(15, 1));
            w_m[1][c] = 8'($urandom_range(127, 1));
            w_m[3][c] = w_m[1][c];
            w_m[0][c] = 8'(-int'($urandom_range(128, 1)));
            w_m[2][c] = 8'(-int'($urandom_range(128, 1)));
        end
        run_pass(1'b0);
        check("tie_class", bus.gesture_class, 2'd1);

        fill_random(0, 15);
        run_pass(1'b0);

        // Largest magnitudes, every score negative.
        for (int c = 0; c < NCELL; c++) begin
            feat_m[c] = 4'd15;
            for (int k = 0; k < NC - 1; k++) w_m[k][c] = -8'sd128;
            w_m[NC-1][c] = -8'sd127;
        end
        run_pass(1'b0);
        check("neg_class", bus.gesture_class, 2'd3);

        // Activity threshold edges.
        fill_count(MINACT);
        run_pass(1'b0);
        check("thresh_at_valid", bus.gesture_valid, 1'b1);
        fill_count(MINACT - 1);
        run_pass(1'b0);
        check("thresh_below_valid", bus.gesture_valid, 1'b0);

        // Abort 100 cycles into a pass keeps the previous results.
        saved = last_exp;
        fill_random(0, 15);
        @(negedge clk);
        n0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy",  bus.busy, 1'b0);
        check("abort_rd_en", bus.rd_en, 1'b0);
        repeat (LAT + 20) @(negedge clk);
        check("abort_no_done",  done_cnt, n0);
        check("abort_scores",   bus.scores, saved.scores);
        check("abort_activity", bus.activity, saved.act);
        check("abort_class",    bus.gesture_class, saved.cls);
        check("abort_valid",    bus.gesture_valid, saved.vld);

        // start together with abort in IDLE: start is taken.
        run_pass(1'b1);

        // start held high through a whole pass.
        begin
            exp_t e;
            bit   seen;
            fill_random(0, 15);
            e = model();
            @(negedge clk);
            n0 = done_cnt;
            e.start_cyc = cyc;
            sb.push_back(e);
            bus.start = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < LAT + 20; i++) begin
                @(negedge clk);
                #1;
                if (done_cnt != n0) begin
                    seen = 1'b1;
                    break;
                end
            end
            bus.start = 1'b0;
            check("repulse_done_seen", seen, 1'b1);
            repeat (40) @(negedge clk);
            check("repulse_one_done", done_cnt, n0 + 1);
        end

        // Reset mid-RUN clears everything, including held results.
        fill_random(1, 15);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/gesture_score_sequencer.md
Name: gesture_score_sequencer

Overview:
Sequences one full classification pass over the cell grid. It sweeps a shared cell address through all NUM_CELLS entries and drives that address to every per-class weight ROM and to the feature (event-count) memory. It accumulates one signed dot product per class and registers the argmax as the detected gesture. It sits between the feature accumulator grid and the gesture output/UART logic.

Parameters:
- NUM_CLASSES, 4, gesture classes: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- NUM_CELLS, 1024, grid cells swept per pass.
- WEIGHT_BITS, 8, signed weight width.
- FEAT_BITS, 4, unsigned feature value width.
- ACC_BITS, 24, signed per-class accumulator width. Must be ≥ FEAT_BITS+WEIGHT_BITS+1+clog2(NUM_CELLS).
- MIN_ACTIVITY, 32, minimum total feature sum for a valid gesture.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, request a pass. Sampled only in IDLE.
- abort, in, 1, cancel the pass in progress.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when results update.
- rd_en, out, 1, high while cell_addr is valid (RUN state).
- cell_addr, out, clog2(NUM_CELLS), shared address to the ROMs and the feature memory.
- feat_data, in, FEAT_BITS, feature memory read data, 1-cycle latency.
- weight_data, in, NUM_CLASSES*WEIGHT_BITS, concatenated ROM outputs, class k at bits [k*WEIGHT_BITS +: WEIGHT_BITS], 1-cycle latency.
- scores, out, NUM_CLASSES*ACC_BITS, registered final class scores, same packing.
- activity, out, FEAT_BITS+clog2(NUM_CELLS), registered sum of feat_data over the pass.
- gesture_class, out, clog2(NUM_CLASSES), argmax class.
- gesture_valid, out, 1, activity ≥ MIN_ACTIVITY.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; busy, done, rd_en, gesture_valid = 0; cell_addr, scores, activity, gesture_class = 0; accumulators = 0.
- States: IDLE → RUN → DRAIN → ARGMAX → DONE → IDLE.
- IDLE:
  - When start=1, clear accumulators and the activity sum, set cell_addr=0, go to RUN.
  - start in any other state is ignored; it is not queued.
- RUN:
  - rd_en=1; cell_addr increments by 1 each cycle.
  - After the cycle that presents NUM_CELLS-1, go to DRAIN. cell_addr returns to 0; it does not wrap into a second sweep.
- Datapath pipeline: a one-cycle valid flag (rd_en delayed by 1) qualifies feat_data/weight_data. When qualified:
  - acc[k] += signed(weight_k) * signed({1'b0, feat_data});
  - activity_sum += feat_data.
  - Arithmetic is full width with no saturation; ACC_BITS is sized so overflow cannot occur.
- DRAIN: one cycle; accumulates the data returned for the last address.
- ARGMAX:
  - Compare the NUM_CLASSES accumulators as signed values.
  - Strictly greater wins; ties go to the lowest index.
  - Register scores, activity, gesture_class, and gesture_valid=(activity_sum ≥ MIN_ACTIVITY).
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: if start is sampled at edge E0, done is high during the cycle following edge E0+NUM_CELLS+2 (1027 cycles after start for the default NUM_CELLS=1024).
- Output holding: registered outputs hold their values until the next ARGMAX. They are not cleared by start or abort.
- abort:
  - In RUN, DRAIN or ARGMAX: next state IDLE, rd_en=0, no done, outputs unchanged.
  - abort has priority over a same-cycle state transition.
  - abort in IDLE or DONE has no effect; the done pulse still occurs.
- start and abort together in IDLE: start wins, because abort has no effect in IDLE.
- rst mid-pass: everything returns to reset values, including previously registered results.

Test Plan:
- Feature memory: feat=1 in rows 0–15, 0 elsewhere. Weight ROMs: UP weight = 6*(16-cy) for cy<16, -4*(cy-15) otherwise. Pulse start → done at cycle 1027; gesture_class=0; gesture_valid=1; activity=512; scores[0]=32*6*(1+…+16)=26112.
- All features 0, any weights → done fires; activity=0; gesture_valid=0; scores all 0; gesture_class=0 (tie → lowest index).
- Identical weights for classes 1 and 3, both maximal → gesture_class=1.
- abort asserted 100 cycles after start → busy drops the next cycle; no done; scores/gesture_class keep the previous pass's values. A new start then completes normally.
- start re-pulsed every cycle during a pass → exactly one done per pass; cell_addr sequence 0..1023 with no restarts.
- rst asserted mid-RUN → the next cycle shows all outputs at reset values and state IDLE.
